// File: rtl/rst_pkg.sv
// Shared types and constants for the reset release sequencer.
// Holds the sequencer state enum, counter-width helper and parameter defaults.
package rst_pkg;

    typedef enum logic [2:0] {
        HOLD,
        STRETCH,
        STEP,
        RUN,
        ACK
    } state_t;

    localparam int DEF_CHAINS  = 2;
    localparam int DEF_NUM_OUT = 3;
    localparam int DEF_STRETCH = 16;
    localparam int DEF_STEP    = 8;

    // Wide enough to hold the larger terminal count without wrapping.
    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Reset deassertion synchronizer: async assert, clk-synchronous release.
// Ports: clk, async_rst_i (active-low), sync_rst_n (last flop of the chain).
module rst_sync_chain #(
    parameter int CHAINS = 2
) (
    input  logic clk,
    input  logic async_rst_i,
    output logic sync_rst_n
);

    logic [CHAINS-1:0] q;

    always_ff @(posedge clk or negedge async_rst_i) begin
        if (!async_rst_i) begin
            q <= '0;
        end else begin
            q <= {q[CHAINS-2:0], 1'b1};
        end
    end

    assign sync_rst_n = q[CHAINS-1];

endmodule

// File: rtl/rst_release_sequencer.sv
// Reset release sequencer: asserts all resets asynchronously, releases them
// in order after a power-on stretch; supports a four-phase soft-reset rerun.
// Ports: clk, async_rst_i (active-low), soft_rst_req_i, soft_rst_ack_o,
//        rst_n_o[NUM_OUT] (bit 0 released first), rst_done_o.
module rst_release_sequencer
    import rst_pkg::*;
#(
    parameter int CHAINS         = DEF_CHAINS,
    parameter int NUM_OUT        = DEF_NUM_OUT,
    parameter int STRETCH_CYCLES = DEF_STRETCH,
    parameter int STEP_CYCLES    = DEF_STEP
) (
    input  logic               clk,
    input  logic               async_rst_i,
    input  logic               soft_rst_req_i,
    output logic               soft_rst_ack_o,
    output logic [NUM_OUT-1:0] rst_n_o,
    output logic               rst_done_o
);

    localparam int CW = cnt_width(STRETCH_CYCLES, STEP_CYCLES);
    localparam logic [CW-1:0] S_LAST = CW'(STRETCH_CYCLES - 1);
    localparam logic [CW-1:0] T_LAST = CW'(STEP_CYCLES - 1);

    logic               sync_rst_n;
    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_OUT-1:0] rst_n_q, rst_n_d;
    logic               done_q, done_d;
    logic               ack_q, ack_d;
    logic               soft_q, soft_d;
    logic [NUM_OUT-1:0] rel;

    rst_sync_chain #(
        .CHAINS(CHAINS)
    ) u_sync (
        .clk        (clk),
        .async_rst_i(async_rst_i),
        .sync_rst_n (sync_rst_n)
    );

    // Released bits form a thermometer code; the next release is one more bit.
    assign rel = (rst_n_q << 1) | NUM_OUT'(1);

    always_ff @(posedge clk or negedge async_rst_i) begin
        if (!async_rst_i) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            rst_n_q <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
            soft_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_n_q <= rst_n_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
            soft_q  <= soft_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        rst_n_d = rst_n_q;
        done_d  = done_q;
        ack_d   = ack_q;
        soft_d  = soft_q;
        unique case (state_q)
            HOLD: begin
                if (sync_rst_n) state_d = STRETCH;
            end
            STRETCH, STEP: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == ((state_q == STRETCH) ? S_LAST : T_LAST)) begin
                    cnt_d   = '0;
                    rst_n_d = rel;
                    state_d = STEP;
                    if (&rel) begin
                        done_d = 1'b1;
                        // Soft path completes the handshake in ACK.
                        if (soft_q) begin
                            state_d = ACK;
                            ack_d   = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
            end
            RUN: begin
                if (soft_rst_req_i) begin
                    rst_n_d = '0;
                    done_d  = 1'b0;
                    soft_d  = 1'b1;
                    state_d = STRETCH;
                end
            end
            ACK: begin
                if (!soft_rst_req_i) begin
                    ack_d   = 1'b0;
                    soft_d  = 1'b0;
                    state_d = RUN;
                end
            end
            default: state_d = HOLD;
        endcase
    end

    assign rst_n_o        = rst_n_q;
    assign rst_done_o     = done_q;
    assign soft_rst_ack_o = ack_q;

endmodule

// File: tb/tb_rst_release_sequencer.sv
// Directed bench for rst_release_sequencer (default instance plus a
// NUM_OUT=1 / STRETCH_CYCLES=1 / CHAINS=3 corner instance).
module tb_rst_release_sequencer;

    logic       clk = 1'b0;
    logic       arst = 1'b0;
    logic       req = 1'b0;
    logic       ack;
    logic [2:0] rst_n;
    logic       done;

    logic       arst2 = 1'b0;
    logic       req2 = 1'b0;
    logic       ack2;
    logic [0:0] rst_n2;
    logic       done2;

    int n_cmp = 0;
    int n_bad = 0;
    int ed = 0;

    always #5 clk = ~clk;

    rst_release_sequencer u_dut (
        .clk           (clk),
        .async_rst_i   (arst),
        .soft_rst_req_i(req),
        .soft_rst_ack_o(ack),
        .rst_n_o       (rst_n),
        .rst_done_o    (done)
    );

    rst_release_sequencer #(
        .CHAINS        (3),
        .NUM_OUT       (1),
        .STRETCH_CYCLES(1),
        .STEP_CYCLES   (8)
    ) u_cor (
        .clk           (clk),
        .async_rst_i   (arst2),
        .soft_rst_req_i(req2),
        .soft_rst_ack_o(ack2),
        .rst_n_o       (rst_n2),
        .rst_done_o    (done2)
    );

    // Expected released bits for a sequence whose bit 0 releases at edge b.
    function automatic logic [2:0] therm(input int e, input int b);
        logic [2:0] r;
        for (int i = 0; i < 3; i++) r[i] = (e >= b + i * 8);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        ed++;
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if ({rst_n, done, ack} !== 5'b0) begin
                n_bad++;
                $display("FAIL reset k=%0d got rst_n=%b done=%b ack=%b want 000/0/0",
                         k, rst_n, done, ack);
            end
            n_cmp++;
            if ({rst_n2, done2, ack2} !== 3'b0) begin
                n_bad++;
                $display("FAIL reset_corner k=%0d got %b%b%b want 000",
                         k, rst_n2, done2, ack2);
            end
        end
    endtask

    task automatic test_power_on(input string tag);
        arst = 1'b1;
        ed = 0;
        while (ed < 40) begin
            tick();
            n_cmp++;
            if (rst_n !== therm(ed, 19) || done !== (ed >= 35) || ack !== 1'b0) begin
                n_bad++;
                $display("FAIL %s edge=%0d got rst_n=%b done=%b ack=%b want %b/%b/0",
                         tag, ed, rst_n, done, ack, therm(ed, 19), ed >= 35);
            end
        end
    endtask

    task automatic test_soft();
        while (ed < 145) begin
            if (ed == 99) req = 1'b1;
            if (ed == 139) req = 1'b0;
            tick();
            n_cmp++;
            if (rst_n !== ((ed < 100) ? 3'b111 : therm(ed, 116)) ||
                done !== (ed < 100 || ed >= 132) ||
                ack !== (ed >= 132 && ed < 140)) begin
                n_bad++;
                $display("FAIL soft edge=%0d got rst_n=%b done=%b ack=%b",
                         ed, rst_n, done, ack);
            end
        end
    endtask

    task automatic test_abort();
        while (ed < 174) begin
            if (ed == 149) req = 1'b1;
            tick();
            n_cmp++;
            if (rst_n !== ((ed < 150) ? 3'b111 : therm(ed, 166)) ||
                done !== (ed < 150)) begin
                n_bad++;
                $display("FAIL abort_pre edge=%0d got rst_n=%b done=%b",
                         ed, rst_n, done);
            end
        end
        #2;
        arst = 1'b0;
        req = 1'b0;
        #1;
        n_cmp++;
        if ({rst_n, done, ack} !== 5'b0) begin
            n_bad++;
            $display("FAIL abort_async got rst_n=%b done=%b ack=%b want 000/0/0",
                     rst_n, done, ack);
        end
        repeat (3) tick();
        test_power_on("abort_repeat");
    endtask

    task automatic test_ignored_req();
        arst = 1'b0;
        repeat (3) tick();
        arst = 1'b1;
        req = 1'b1;
        ed = 0;
        while (ed < 72) begin
            if (ed == 70) req = 1'b0;
            tick();
            n_cmp++;
            if (rst_n !== ((ed < 36) ? therm(ed, 19) : therm(ed, 52)) ||
                done !== ((ed >= 35 && ed < 36) || ed >= 68) ||
                ack !== (ed >= 68 && ed < 71)) begin
                n_bad++;
                $display("FAIL ignored edge=%0d got rst_n=%b done=%b ack=%b",
                         ed, rst_n, done, ack);
            end
        end
    endtask

    task automatic test_corner();
        arst2 = 1'b1;
        ed = 0;
        while (ed < 8) begin
            tick();
            n_cmp++;
            if (rst_n2 !== 1'(ed >= 5) || done2 !== (ed >= 5) || ack2 !== 1'b0) begin
                n_bad++;
                $display("FAIL corner edge=%0d got rst_n=%b done=%b ack=%b want %b",
                         ed, rst_n2, done2, ack2, ed >= 5);
            end
        end
    endtask

    task automatic test_glitch();
        tick();
        n_cmp++;
        if (rst_n !== 3'b111 || done !== 1'b1) begin
            n_bad++;
            $display("FAIL glitch_pre got rst_n=%b done=%b want 111/1", rst_n, done);
        end
        #3;
        arst = 1'b0;
        #1;
        arst = 1'b1;
        #1;
        n_cmp++;
        if ({rst_n, done, ack} !== 5'b0) begin
            n_bad++;
            $display("FAIL glitch_async got rst_n=%b done=%b ack=%b want 000/0/0",
                     rst_n, done, ack);
        end
        test_power_on("glitch_repeat");
    endtask

    initial begin
        test_reset();
        test_power_on("power_on");
        test_soft();
        test_abort();
        test_ignored_req();
        test_corner();
        test_glitch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
